// File: rtl/regfile_param_if.sv
// rtl/regfile_param_if.sv - register file port bundle (decode/writeback side is master)
interface regfile_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              regWrite;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic [ADDR_W-1:0] readReg1;
  logic [ADDR_W-1:0] readReg2;
  logic [DATA_W-1:0] readData1;
  logic [DATA_W-1:0] readData2;
  logic              ready;
  logic              wr_drop;

  modport master (
    output regWrite, writeReg, writeData, readReg1, readReg2,
    input  readData1, readData2, ready, wr_drop
  );

  modport slave (
    input  regWrite, writeReg, writeData, readReg1, readReg2,
    output readData1, readData2, ready, wr_drop
  );
endinterface

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised 2R/1W register file with post-reset clear sequencer
// Optional same-cycle write-to-read forwarding: define REGFILE_BYPASS_EN.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  regfile_param_if.slave  bus
);
  localparam int       DEPTH   = 2 ** ADDR_W;
  localparam logic     ZERO_EN = (ZERO_REG != 0);
  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              ready_q, ready_d;
  logic              wr_drop_q, wr_drop_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [DATA_W-1:0] rd1, rd2;

  // The clear sequencer owns the single write port until the last entry is zeroed.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    ready_d   = ready_q;
    wr_drop_d = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = bus.writeReg;
    mem_wdata = bus.writeData;
    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        wr_drop_d = bus.regWrite;
        if (&clr_ptr_q) begin
          state_d = S_RUN;
          ready_d = 1'b1;
        end
      end
      default: begin
        mem_we = bus.regWrite && !(ZERO_EN && (bus.writeReg == '0));
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    rd1 = mem_q[bus.readReg1];
    rd2 = mem_q[bus.readReg2];
`ifdef REGFILE_BYPASS_EN
    if (bus.regWrite && (bus.writeReg == bus.readReg1)) rd1 = bus.writeData;
    if (bus.regWrite && (bus.writeReg == bus.readReg2)) rd2 = bus.writeData;
`endif
    // Hardwired zero also masks any forwarded value aimed at entry 0.
    if (ZERO_EN && (bus.readReg1 == '0)) rd1 = '0;
    if (ZERO_EN && (bus.readReg2 == '0)) rd2 = '0;
    if (state_q != S_RUN) begin
      rd1 = '0;
      rd2 = '0;
    end
  end

  assign bus.readData1 = rd1;
  assign bus.readData2 = rd2;
  assign bus.ready     = ready_q;
  assign bus.wr_drop   = wr_drop_q;
endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - directed self-checking bench for regfile_param (default and small configs)
module tb_regfile_param;
  logic clk;
  logic rst;
  logic rst_s;
  int   errors;
  int   checks;

  regfile_param_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  regfile_param_if #(.DATA_W(32), .ADDR_W(3)) bus_s ();

  regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  regfile_param #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(0)) u_small (
    .clk (clk),
    .rst (rst_s),
    .bus (bus_s.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready: ready=%b after %0d cycles, required 1", bus.ready, n);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset();
    wait_ready(100);
    bus.regWrite = 1'b1; bus.writeReg = 5'd7; bus.writeData = 32'hDEADBEEF;
    step();
    bus.regWrite = 1'b0; bus.readReg1 = 5'd7;
    #1;
    checks++;
    if (bus.readData1 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL preload_x7: got %h, required deadbeef", bus.readData1);
    end
    rst = 1'b1;
    step();
    checks++;
    if (bus.ready !== 1'b0 || bus.wr_drop !== 1'b0 || bus.readData1 !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: ready=%b wr_drop=%b rd1=%h, required 0 0 0", bus.ready, bus.wr_drop, bus.readData1);
    end
    step();
    rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      step();
      checks++;
      if (bus.ready !== (i == 32)) begin
        errors++; $display("FAIL clear_len edge %0d: ready=%b, required %b", i, bus.ready, (i == 32));
      end
    end
    for (int a = 0; a < 32; a++) begin
      bus.readReg1 = a[4:0];
      bus.readReg2 = 5'(31 - a);
      #1;
      checks++;
      if (bus.readData1 !== 32'd0 || bus.readData2 !== 32'd0) begin
        errors++;
        $display("FAIL cleared addr %0d: rd1=%h rd2=%h, required 0 0", a, bus.readData1, bus.readData2);
      end
    end
  endtask

  task automatic test_rw();
    bus.regWrite = 1'b1; bus.writeReg = 5'd5; bus.writeData = 32'h12345678;
    step();
    bus.writeReg = 5'd6; bus.writeData = 32'hCAFEF00D; bus.readReg1 = 5'd5;
    #1;
    checks++;
    if (bus.readData1 !== 32'h12345678) begin
      errors++; $display("FAIL rw_x5: got %h, required 12345678", bus.readData1);
    end
    step();
    bus.writeReg = 5'd0; bus.writeData = 32'hFFFFFFFF; bus.readReg2 = 5'd6;
    #1;
    checks++;
    if (bus.readData2 !== 32'hCAFEF00D || bus.readData1 !== 32'h12345678) begin
      errors++; $display("FAIL rw_x6: rd1=%h rd2=%h, required 12345678 cafef00d", bus.readData1, bus.readData2);
    end
    step();
    bus.regWrite = 1'b0; bus.readReg1 = 5'd0;
    #1;
    checks++;
    if (bus.readData1 !== 32'd0 || bus.wr_drop !== 1'b0) begin
      errors++; $display("FAIL x0_write: rd1=%h wr_drop=%b, required 0 0", bus.readData1, bus.wr_drop);
    end
  endtask

  task automatic test_drop();
    bus.regWrite = 1'b1; bus.writeReg = 5'd12; bus.writeData = 32'h0BADF00D;
    step();
    bus.regWrite = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) step();
    bus.readReg1 = 5'd12;
    #1;
    checks++;
    if (bus.readData1 !== 32'd0) begin
      errors++; $display("FAIL clear_read_gate: got %h, required 0", bus.readData1);
    end
    bus.regWrite = 1'b1; bus.writeReg = 5'd3; bus.writeData = 32'hA5A5A5A5;
    step();
    bus.regWrite = 1'b0;
    #1;
    checks++;
    if (bus.wr_drop !== 1'b1) begin
      errors++; $display("FAIL wr_drop_set: got %b, required 1", bus.wr_drop);
    end
    step();
    checks++;
    if (bus.wr_drop !== 1'b0) begin
      errors++; $display("FAIL wr_drop_pulse: got %b, required 0", bus.wr_drop);
    end
    wait_ready(40);
    bus.readReg1 = 5'd3;
    #1;
    checks++;
    if (bus.readData1 !== 32'd0) begin
      errors++; $display("FAIL drop_x3: got %h, required 0", bus.readData1);
    end
  endtask

  task automatic test_mid_clear_reset();
    pulse_reset();
    for (int i = 0; i < 20; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      step();
      if (i == 12 || i == 31 || i == 32) begin
        checks++;
        if (bus.ready !== (i == 32)) begin
          errors++; $display("FAIL mid_clear edge %0d: ready=%b, required %b", i, bus.ready, (i == 32));
        end
      end
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_same;
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'h0000BEEF;
`else
    exp_same = 32'h0;
`endif
    bus.readReg2 = 5'd9;
    bus.regWrite = 1'b1; bus.writeReg = 5'd9; bus.writeData = 32'h0000BEEF;
    #1;
    checks++;
    if (bus.readData2 !== exp_same) begin
      errors++; $display("FAIL bypass_same: got %h, required %h", bus.readData2, exp_same);
    end
    step();
    bus.writeReg = 5'd0; bus.writeData = 32'h11111111; bus.readReg1 = 5'd0;
    #1;
    checks++;
    if (bus.readData2 !== 32'h0000BEEF || bus.readData1 !== 32'd0) begin
      errors++; $display("FAIL bypass_next: rd2=%h rd1=%h, required 0000beef 0", bus.readData2, bus.readData1);
    end
    step();
    bus.regWrite = 1'b0;
  endtask

  task automatic test_small();
    rst_s = 1'b1;
    step();
    rst_s = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i >= 7) begin
        checks++;
        if (bus_s.ready !== (i == 8)) begin
          errors++; $display("FAIL small_clear edge %0d: ready=%b, required %b", i, bus_s.ready, (i == 8));
        end
      end
    end
    bus_s.regWrite = 1'b1; bus_s.writeReg = 3'd0; bus_s.writeData = 32'h55;
    step();
    bus_s.regWrite = 1'b0; bus_s.readReg1 = 3'd0; bus_s.readReg2 = 3'd0;
    #1;
    checks++;
    if (bus_s.readData1 !== 32'h55 || bus_s.readData2 !== 32'h55) begin
      errors++; $display("FAIL small_x0: rd1=%h rd2=%h, required 55 55", bus_s.readData1, bus_s.readData2);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    rst_s = 1'b1;
    bus.regWrite = 1'b0; bus.writeReg = '0; bus.writeData = '0;
    bus.readReg1 = '0; bus.readReg2 = '0;
    bus_s.regWrite = 1'b0; bus_s.writeReg = '0; bus_s.writeData = '0;
    bus_s.readReg1 = '0; bus_s.readReg2 = '0;
    test_reset();
    test_rw();
    test_drop();
    test_mid_clear_reset();
    test_bypass();
    test_small();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
